// File: rtl/bioz_pkg.sv
// rtl/bioz_pkg.sv - shared types and widths for the BioZ ADC capture path
package bioz_pkg;

    localparam int BIOZ_TAG_W = 8;
    localparam int BIOZ_ADC_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUSH  = 2'd2
    } capt_state_t;

    typedef struct packed {
        logic [3:0] fsel;
        logic [1:0] row;
        logic [1:0] col;
    } bioz_tag_t;

endpackage

// File: rtl/bioz_sample_fifo.sv
// rtl/bioz_sample_fifo.sv - first-word fall-through sample FIFO with full/empty flags
module bioz_sample_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/bioz_adc_capture.sv
// rtl/bioz_adc_capture.sv - serial SAR capture FSM with tagging and sample buffering
module bioz_adc_capture
    import bioz_pkg::*;
#(
    parameter int DATA_W     = BIOZ_ADC_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = BIOZ_TAG_W
) (
    input  logic              clk_ADC,
    input  logic              Reset,
    input  logic              ADC_En,
    input  logic              ADC_Start,
    input  logic              ADC_Dout,
    input  logic [3:0]        Fsel,
    input  logic [1:0]        Row,
    input  logic [1:0]        Col,
    output logic [DATA_W-1:0] Sample_Data,
    output logic [TAG_W-1:0]  Sample_Tag,
    output logic              Sample_Valid,
    input  logic              Sample_Ready,
    output logic              Busy,
    output logic              Overflow,
    output logic              Frame_Err
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W - 1);

    capt_state_t       state;
    capt_state_t       state_next;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     bit_cnt;
    logic [TAG_W-1:0]  tag_q;
    bioz_tag_t         tag_in;
    logic              busy_q;
    logic              overflow_q;
    logic              frame_err_q;
    logic              push_req;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [TAG_W+DATA_W-1:0] fifo_dout;

    assign tag_in = '{fsel: Fsel, row: Row, col: Col};

    always_ff @(posedge clk_ADC) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        case (state)
            IDLE: begin
                if (ADC_En && ADC_Start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!ADC_En) begin
                    state_next = IDLE;
                end else if (bit_cnt == '0) begin
                    state_next = PUSH;
                end
            end
            PUSH: begin
                state_next = IDLE;
                push_req   = ADC_En;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_ADC) begin
        if (Reset) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            tag_q       <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            busy_q <= (state_next != IDLE);
            if (state == IDLE && ADC_En && ADC_Start) begin
                tag_q   <= TAG_W'(tag_in);
                bit_cnt <= CNT_MAX;
            end
            if (state == SHIFT && ADC_En) begin
                shreg   <= {shreg[DATA_W-2:0], ADC_Dout};
                bit_cnt <= bit_cnt - CW'(1);
            end
            // A start while busy never restarts capture; it only marks a framing fault.
            if (ADC_Start && state != IDLE) begin
                frame_err_q <= 1'b1;
            end
            if (push_req && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign pop = Sample_Valid && Sample_Ready;

    bioz_sample_fifo #(
        .WIDTH (TAG_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_ADC),
        .rst   (Reset),
        .push  (push_req),
        .din   ({tag_q, shreg}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign Sample_Valid = !fifo_empty;
    assign Sample_Data  = fifo_dout[DATA_W-1:0];
    assign Sample_Tag   = fifo_dout[TAG_W+DATA_W-1:DATA_W];
    assign Busy         = busy_q;
    assign Overflow     = overflow_q;
    assign Frame_Err    = frame_err_q;

endmodule

// File: tb/tb_bioz_adc_capture.sv
// tb/tb_bioz_adc_capture.sv - randomized self-checking bench for bioz_adc_capture
module tb_bioz_adc_capture;

    localparam int DW    = 12;
    localparam int TW    = 8;
    localparam int DEPTH = 4;

    logic          clk_ADC;
    logic          Reset;
    logic          ADC_En;
    logic          ADC_Start;
    logic          ADC_Dout;
    logic [3:0]    Fsel;
    logic [1:0]    Row;
    logic [1:0]    Col;
    logic [DW-1:0] Sample_Data;
    logic [TW-1:0] Sample_Tag;
    logic          Sample_Valid;
    logic          Sample_Ready;
    logic          Busy;
    logic          Overflow;
    logic          Frame_Err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [TW+DW-1:0] q[$];
    bit m_ovf;
    bit m_ferr;

    bioz_adc_capture dut (
        .clk_ADC      (clk_ADC),
        .Reset        (Reset),
        .ADC_En       (ADC_En),
        .ADC_Start    (ADC_Start),
        .ADC_Dout     (ADC_Dout),
        .Fsel         (Fsel),
        .Row          (Row),
        .Col          (Col),
        .Sample_Data  (Sample_Data),
        .Sample_Tag   (Sample_Tag),
        .Sample_Valid (Sample_Valid),
        .Sample_Ready (Sample_Ready),
        .Busy         (Busy),
        .Overflow     (Overflow),
        .Frame_Err    (Frame_Err)
    );

    initial begin
        clk_ADC = 1'b0;
        forever #5 clk_ADC = ~clk_ADC;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare against the queue model, then apply the edge to the model.
    task automatic cyc(input logic st, input logic dn, input logic en, input logic rdy,
                       input bit busy_e, input bit ps, input logic [TW+DW-1:0] ent);
        bit popped;
        ADC_Start    = st;
        ADC_Dout     = dn;
        ADC_En       = en;
        Sample_Ready = rdy;
        Fsel         = ent[TW+DW-1 -: 4];
        Row          = ent[DW+3 -: 2];
        Col          = ent[DW+1 -: 2];
        #1;
        check("valid", 32'(Sample_Valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("data", 32'(Sample_Data), 32'(q[0][DW-1:0]));
            check("tag", 32'(Sample_Tag), 32'(q[0][TW+DW-1:DW]));
        end
        check("busy", 32'(Busy), 32'(busy_e));
        check("overflow", 32'(Overflow), 32'(m_ovf));
        check("frame_err", 32'(Frame_Err), 32'(m_ferr));
        @(posedge clk_ADC);
        popped = rdy && (q.size() != 0);
        if (st && busy_e) m_ferr = 1'b1;
        if (popped) void'(q.pop_front());
        if (ps) begin
            if (q.size() == DEPTH) m_ovf = 1'b1;
            else q.push_back(ent);
        end
        @(negedge clk_ADC);
    endtask

    // Tag is presented only on cycle 0; other cycles drive a scrambled tag to prove it was latched.
    task automatic conv(input logic [DW-1:0] w, input logic [TW-1:0] tg, input int rmode,
                        input int err_at, input int drop_at, input int stop_at, input int gap);
        bit busy_e;
        logic st, dn, en, rdy;
        bit ps;
        logic [TW+DW-1:0] ent;
        busy_e = 1'b0;
        for (int c = 0; c <= 13 + gap; c++) begin
            if (c == stop_at) return;
            st  = (c == 0) || (c == err_at);
            dn  = (c >= 1 && c <= DW) ? w[DW - c] : 1'($urandom);
            en  = (c != drop_at);
            case (rmode)
                0:       rdy = 1'b0;
                1:       rdy = 1'b1;
                2:       rdy = 1'($urandom);
                default: rdy = (c == 13);
            endcase
            ps  = (c == 13) && (drop_at < 0);
            ent = (c == 0 || ps) ? {tg, w} : {TW'($urandom), w};
            cyc(st, dn, en, rdy, busy_e, ps, ent);
            busy_e = (c <= 12) && !(drop_at >= 0 && c >= drop_at);
        end
    endtask

    task automatic do_reset();
        Reset        = 1'b1;
        ADC_Start    = 1'b0;
        ADC_En       = 1'b1;
        Sample_Ready = 1'b1;
        @(posedge clk_ADC);
        q.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        @(negedge clk_ADC);
        Reset = 1'b0;
    endtask

    task automatic drain(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            seen += int'(Sample_Valid);
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        end
    endtask

    initial begin
        int seen;
        int rmode, sel, err_at, drop_at;
        Reset = 1'b1; ADC_En = 1'b0; ADC_Start = 1'b0; ADC_Dout = 1'b0;
        Fsel = '0; Row = '0; Col = '0; Sample_Ready = 1'b0;
        m_ovf = 1'b0; m_ferr = 1'b0;
        @(negedge clk_ADC);
        do_reset();
        #1;
        check("rst_data", 32'(Sample_Data), 32'd0);
        check("rst_tag", 32'(Sample_Tag), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Nominal capture, then a single pop.
        conv(12'hA5C, {4'hC, 2'd1, 2'd2}, 0, -1, -1, -1, 0);
        drain(2, seen);
        check("nominal_count", 32'(seen), 32'd1);

        // Back-to-back at the 15-cycle start period.
        conv(12'h001, 8'h11, 0, -1, -1, -1, 1);
        conv(12'hFFF, 8'h22, 0, -1, -1, -1, 1);
        conv(12'h800, 8'h33, 0, -1, -1, -1, 1);
        drain(4, seen);
        check("b2b_count", 32'(seen), 32'd3);

        // Fifth conversion into a full FIFO is dropped.
        for (int i = 0; i < 5; i++) conv(DW'(12'h100 + i), TW'(i), 0, -1, -1, -1, 1);
        check("overflow_set", 32'(Overflow), 32'd1);
        drain(5, seen);
        check("overflow_count", 32'(seen), 32'd4);

        // Start inside a conversion, then enable dropped mid-shift.
        conv(12'h5A3, 8'h5A, 0, 5, -1, -1, 1);
        check("frame_err_set", 32'(Frame_Err), 32'd1);
        conv(12'h777, 8'h77, 0, -1, 7, -1, 1);
        drain(3, seen);
        check("frame_drop_count", 32'(seen), 32'd1);

        // Reset at cycle 8 with two samples queued and both flags set.
        conv(12'h0F0, 8'hA1, 0, -1, -1, -1, 1);
        conv(12'h0E0, 8'hA2, 0, -1, -1, -1, 1);
        conv(12'h0D0, 8'hA3, 0, -1, -1, 8, 0);
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        conv(12'hA5C, 8'hC6, 0, -1, -1, -1, 0);
        drain(2, seen);
        check("post_reset_count", 32'(seen), 32'd1);

        // Full FIFO with a pop in the PUSH cycle: no overflow, occupancy stays four.
        for (int i = 0; i < 4; i++) conv(DW'(12'h200 + i), TW'(8'h40 + i), 0, -1, -1, -1, 1);
        conv(12'h2FF, 8'h4F, 3, -1, -1, -1, 0);
        check("full_pop_ovf", 32'(Overflow), 32'd0);
        drain(5, seen);
        check("full_pop_count", 32'(seen), 32'd4);

        // Randomized conversions with mixed back-pressure, faults and start spacing.
        for (int n = 0; n < 40; n++) begin
            rmode   = $urandom_range(0, 2);
            sel     = $urandom_range(0, 9);
            err_at  = (sel == 0) ? $urandom_range(1, 13) : -1;
            drop_at = (sel == 1) ? $urandom_range(1, 13) : -1;
            conv(DW'($urandom), TW'($urandom), rmode, err_at, drop_at, -1, $urandom_range(0, 3));
            if (sel == 2) drain(3, seen);
        end
        drain(5, seen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
